// File: rtl/jclock_stepper_if.sv
// Control and status bundle for the CPU clock/stepper front end.
// Ports: whalt/wsingle/wstep_rst (controls into the stepper),
//        wclk_e/wclk_s/wstep/wphase/wtick/whalted (decoded state out).
interface jclock_stepper_if #(
  parameter int NSTEPS = 6
);
  logic              whalt;
  logic              wsingle;
  logic              wstep_rst;
  logic              wclk_e;
  logic              wclk_s;
  logic [NSTEPS-1:0] wstep;
  logic [1:0]        wphase;
  logic              wtick;
  logic              whalted;

  // Controller side: drives halt/single/step-restart, observes clocks and step.
  modport master (
    output whalt, wsingle, wstep_rst,
    input  wclk_e, wclk_s, wstep, wphase, wtick, whalted
  );

  // Stepper side.
  modport slave (
    input  whalt, wsingle, wstep_rst,
    output wclk_e, wclk_s, wstep, wphase, wtick, whalted
  );
endinterface

// File: rtl/jclock_stepper.sv
// Four-phase CPU clock generator and one-hot instruction stepper with halt/single-tick control.
// Ports: wclk (system clock), wreset (sync active-low reset), bus (jclock_stepper_if.slave).
// Outputs decode registers only; one tick = four wclk cycles, halt/single act at tick boundaries.
module jclock_stepper #(
  parameter int NSTEPS = 6
) (
  input  logic               wclk,
  input  logic               wreset,
  jclock_stepper_if.slave    bus
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    SINGLE = 2'd2
  } mode_t;

  localparam logic [NSTEPS-1:0] STEP0 = {{(NSTEPS-1){1'b0}}, 1'b1};

  mode_t             mode;
  logic [1:0]        phase;
  logic [NSTEPS-1:0] step;
  logic              wsingle_q;
  // Set by reset: the first phase-3 cycle after reset is not a real tick,
  // so it neither pulses wtick nor advances the stepper.
  logic              first;

  logic              active;
  logic [NSTEPS-1:0] step_adv;

  assign active   = (mode != HALTED);
  assign step_adv = (bus.wstep_rst || step[NSTEPS-1]) ? STEP0
                                                      : {step[NSTEPS-2:0], 1'b0};

  always_ff @(posedge wclk) begin
    if (!wreset) begin
      mode      <= RUN;
      phase     <= 2'd3;
      step      <= STEP0;
      wsingle_q <= 1'b0;
      first     <= 1'b1;
    end else begin
      wsingle_q <= bus.wsingle;
      first     <= 1'b0;
      case (mode)
        RUN, SINGLE: begin
          if (phase != 2'd3) begin
            phase <= phase + 2'd1;
          end else if (first) begin
            phase <= 2'd0;
          end else begin
            // Tick boundary: advance the stepper, then either halt
            // (phase parked at 3) or start the next tick.
            step <= step_adv;
            if (mode == SINGLE || bus.whalt) begin
              mode <= HALTED;
            end else begin
              phase <= 2'd0;
            end
          end
        end
        HALTED: begin
          if (bus.wstep_rst) begin
            step <= STEP0;
          end
          // Dropping halt wins over a simultaneous single request.
          if (!bus.whalt) begin
            mode  <= RUN;
            phase <= 2'd0;
          end else if (bus.wsingle && !wsingle_q) begin
            mode  <= SINGLE;
            phase <= 2'd0;
          end
        end
        default: begin
          mode  <= RUN;
          phase <= 2'd3;
        end
      endcase
    end
  end

  assign bus.wclk_e  = active && (phase != 2'd3);
  assign bus.wclk_s  = active && (phase == 2'd1);
  assign bus.wtick   = active && (phase == 2'd3) && !first;
  assign bus.whalted = (mode == HALTED);
  assign bus.wphase  = phase;
  assign bus.wstep   = step;

  a_step_onehot: assert property (@(posedge wclk) disable iff (!wreset) $onehot(step));
  a_set_in_enable: assert property (@(posedge wclk) disable iff (!wreset) bus.wclk_s |-> bus.wclk_e);

endmodule

// File: doc/jclock_stepper.md
Name: jclock_stepper

Overview:
- Sequential timing front end of the gate-level CPU.
- Derives the four-phase CPU clock from one system clock:
  - wclk_e (enable, broad pulse)
  - wclk_s (set, narrow pulse nested inside wclk_e)
- Drives the one-hot instruction stepper that sequences control logic built from the jand/jor/jnot primitives.
- Provides halt and single-tick control for bench and front-panel debugging.

Parameters:
NSTEPS, 6, number of one-hot stepper outputs; legal range 2..16.

Ports:
wclk  input  1  system clock; all state updates on rising edge
wreset  input  1  synchronous, active-low reset
whalt  input  1  level; request halt at the next tick boundary
wsingle  input  1  level; while halted, run exactly one tick (edge-detected internally)
wstep_rst  input  1  level; restart stepper at step 0 at the next tick boundary
wclk_e  output  1  CPU enable clock
wclk_s  output  1  CPU set clock
wstep  output  NSTEPS  one-hot current step
wphase  output  2  current phase 0..3
wtick  output  1  high during phase 3 of an executed tick
whalted  output  1  high while in HALTED state

Behaviour:
- State registers:
  - phase[1:0]
  - mode ∈ {RUN, HALTED, SINGLE}
  - step one-hot [NSTEPS-1:0]
  - wsingle_q (previous wsingle, for rising-edge detect)
- All outputs decode registers only; no input-to-output combinational path.
- Reset (wreset==0 at a rising edge): phase=3, mode=RUN, step=1 (bit 0), wsingle_q=0.
  - Resulting outputs: wclk_e=0, wclk_s=0, wtick=0, whalted=0.
  - Reset overrides everything, including mid-tick or mid-single.
- Phase decode:
  - phase 0: e=1, s=0
  - phase 1: e=1, s=1
  - phase 2: e=1, s=0
  - phase 3: e=0, s=0
  - In HALTED, e and s are forced to 0.
- RUN:
  - phase increments by 1 every cycle, wrapping 3→0.
  - The edge leaving phase 3 is the tick boundary.
- wtick = (phase==3) && mode∈{RUN,SINGLE}.
  - Exception: wtick=0 in the first cycle after reset, because no tick has executed yet (one-cycle flag).
- Tick boundary (edge where phase==3 and mode∈{RUN,SINGLE}, excluding the first post-reset edge):
  - step update: if wstep_rst==1 or step[NSTEPS-1]==1, step←bit 0; else step←step<<1.
  - RUN and whalt==1: mode←HALTED, phase held at 3. Otherwise phase←0.
  - SINGLE: mode←HALTED, phase held at 3. whalt is ignored.
- First post-reset edge: phase 3→0, no step advance, mode stays RUN.
  - Consequence: the first tick after reset executes at step 0.
- HALTED (phase frozen at 3):
  - whalt==0: mode←RUN, phase←0. Resume takes priority over wsingle.
  - else if wsingle rising (wsingle==1 && wsingle_q==0): mode←SINGLE, phase←0.
  - wstep_rst==1 in HALTED: step←bit 0 at the next edge, independent of the other controls.
- SINGLE: identical phase sequencing to RUN, for exactly one tick.
- wsingle_q←wsingle on every edge, in every mode.
- whalted = (mode==HALTED).
- Invariants (checked by assertion):
  - wstep is always exactly one-hot.
  - wclk_s implies wclk_e.

Test Plan:
- Reset then free-run, NSTEPS=6 → per cycle, e/s = 00 (reset phase 3), then 10, 11, 10, 00 repeating. wtick is high on cycle 4 of each tick. wstep goes 000001→000010→…→100000→000001, with the wrap after the 6th tick.
- whalt=1 asserted during phase 1 of the tick at step 2 → tick completes with wtick pulse. Next cycle: whalted=1, wstep=001000, e=s=0, held for 20 cycles.
- From HALTED with whalt=1, pulse wsingle for 3 cycles → exactly one tick (e/s 10,11,10,00), wstep advances by one, whalted=1 again. A second rising edge runs one more tick.
- HALTED, whalt dropped and wsingle raised on the same edge → RUN resumes, phase 0 next cycle, free-run continues (no SINGLE).
- wstep_rst=1 in phase 2 at step 3 → next boundary gives wstep=000001. wstep_rst=1 while HALTED → wstep=000001 on the next edge.
- wreset=0 during phase 1 of SINGLE → next cycle: phase=3, e=s=0, wstep=000001, whalted=0. After release, the first tick executes at step 0.
